// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX->MEM pipeline register.
//   Carries the EX stage's GPR and HI/LO writeback requests to MEM with one
//   cycle of latency, inserts a bubble when EX stalls but MEM runs, and holds
//   everything when both stall. It also parks the partial 64-bit product and
//   step count of multi-cycle MADD/MSUB so EX can resume on the next cycle.
//
// Optional build macro:
//   EX_MEM_FLUSH_EN - adds a 'flush' input (exception squash) that clears the
//                     register like reset, below rst and above all stall cases.
module ex_mem_reg #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int STALL_W = 6,
    parameter int EX_IDX  = 3,
    parameter int MEM_IDX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall,
`ifdef EX_MEM_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic [ADDR_W-1:0]     ex_wd,
    input  logic                  ex_wreg,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic                  ex_whilo,
    input  logic [DATA_W-1:0]     ex_hi,
    input  logic [DATA_W-1:0]     ex_lo,
    input  logic [2*DATA_W-1:0]   hilo_i,
    input  logic [1:0]            cnt_i,
    output logic [ADDR_W-1:0]     mem_wd,
    output logic                  mem_wreg,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_whilo,
    output logic [DATA_W-1:0]     mem_hi,
    output logic [DATA_W-1:0]     mem_lo,
    output logic [2*DATA_W-1:0]   hilo_o,
    output logic [1:0]            cnt_o
);

    localparam logic              WRITE_DISABLE = 1'b0;
    localparam logic [DATA_W-1:0] ZERO_WORD     = '0;

    // What the register does on the coming edge.
    typedef enum logic [1:0] {
        ACT_CLEAR,    // reset (or flush): everything to zero
        ACT_BUBBLE,   // EX stalled, MEM running: zero the request, park MADD/MSUB
        ACT_ADVANCE,  // EX running: pass the request through, drop parked state
        ACT_HOLD      // EX and MEM both stalled: keep every output
    } action_t;

    action_t action;

    // Only the EX and MEM stall bits matter here; the rest belong to other stages.
    logic unused_stall_bits;
    assign unused_stall_bits = &{1'b0, stall};

    // Resolve the edge action from the priority rst > flush > advance > bubble > hold.
    // EX running with MEM stalled is illegal from ctrl and is treated as advance.
    always_comb begin
        // NOTE: default assigned first so no path leaves 'action' unassigned (no latch).
        action = ACT_HOLD;
        if (rst) begin
            action = ACT_CLEAR;
`ifdef EX_MEM_FLUSH_EN
        end else if (flush) begin
            action = ACT_CLEAR;
`endif
        end else if (!stall[EX_IDX]) begin
            action = ACT_ADVANCE;
        end else if (!stall[MEM_IDX]) begin
            action = ACT_BUBBLE;
        end else begin
            action = ACT_HOLD;
        end
    end

    // Pipeline register update; ex_* is only sampled on advance, so junk on a
    // stalled EX stage never reaches MEM.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        unique case (action)
            ACT_CLEAR, ACT_BUBBLE: begin
                mem_wd    <= '0;
                mem_wreg  <= WRITE_DISABLE;
                mem_wdata <= ZERO_WORD;
                mem_whilo <= WRITE_DISABLE;
                mem_hi    <= ZERO_WORD;
                mem_lo    <= ZERO_WORD;
                if (action == ACT_BUBBLE) begin
                    hilo_o <= hilo_i;
                    cnt_o  <= cnt_i;
                end else begin
                    hilo_o <= '0;
                    cnt_o  <= 2'd0;
                end
            end
            ACT_ADVANCE: begin
                mem_wd    <= ex_wd;
                mem_wreg  <= ex_wreg;
                mem_wdata <= ex_wdata;
                mem_whilo <= ex_whilo;
                mem_hi    <= ex_hi;
                mem_lo    <= ex_lo;
                hilo_o    <= '0;
                cnt_o     <= 2'd0;
            end
            ACT_HOLD: begin
                // Registers keep their values.
            end
        endcase
    end

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: scoreboard bench for ex_mem_reg.
//   The driver applies stimulus before each posedge, advances a behavioural
//   model of the register and pushes the expected outputs into a queue; the
//   monitor pops one entry after every posedge and compares it with the DUT.
module tb_ex_mem_reg;

    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;
    localparam int STALL_W = 6;
    localparam int EX_IDX  = 3;
    localparam int MEM_IDX = 4;

    typedef struct packed {
        logic [ADDR_W-1:0]   wd;
        logic                wreg;
        logic [DATA_W-1:0]   wdata;
        logic                whilo;
        logic [DATA_W-1:0]   hi;
        logic [DATA_W-1:0]   lo;
        logic [2*DATA_W-1:0] hilo;
        logic [1:0]          cnt;
    } out_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [STALL_W-1:0]  stall;
    logic                flush;
    logic [ADDR_W-1:0]   ex_wd;
    logic                ex_wreg;
    logic [DATA_W-1:0]   ex_wdata;
    logic                ex_whilo;
    logic [DATA_W-1:0]   ex_hi;
    logic [DATA_W-1:0]   ex_lo;
    logic [2*DATA_W-1:0] hilo_i;
    logic [1:0]          cnt_i;
    logic [ADDR_W-1:0]   mem_wd;
    logic                mem_wreg;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_whilo;
    logic [DATA_W-1:0]   mem_hi;
    logic [DATA_W-1:0]   mem_lo;
    logic [2*DATA_W-1:0] hilo_o;
    logic [1:0]          cnt_o;

    out_t dut_o;
    assign dut_o = {mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, hilo_o, cnt_o};

    ex_mem_reg #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STALL_W(STALL_W),
        .EX_IDX(EX_IDX), .MEM_IDX(MEM_IDX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
`ifdef EX_MEM_FLUSH_EN
        .flush(flush),
`endif
        .ex_wd(ex_wd),
        .ex_wreg(ex_wreg),
        .ex_wdata(ex_wdata),
        .ex_whilo(ex_whilo),
        .ex_hi(ex_hi),
        .ex_lo(ex_lo),
        .hilo_i(hilo_i),
        .cnt_i(cnt_i),
        .mem_wd(mem_wd),
        .mem_wreg(mem_wreg),
        .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo),
        .mem_hi(mem_hi),
        .mem_lo(mem_lo),
        .hilo_o(hilo_o),
        .cnt_o(cnt_o)
    );

    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    int   illegal_cnt = 0;
    out_t model       = '0;
    out_t sb[$];

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: what the register must hold after the coming edge.
    task automatic step();
        out_t nxt;
        bit   do_flush;
`ifdef EX_MEM_FLUSH_EN
        do_flush = flush;
`else
        do_flush = 1'b0;
`endif
        if (!rst && !do_flush && !stall[EX_IDX] && stall[MEM_IDX]) illegal_cnt++;
        if (rst || do_flush) begin
            nxt = '0;
        end else if (!stall[EX_IDX]) begin
            nxt = '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata, whilo: ex_whilo,
                    hi: ex_hi, lo: ex_lo, hilo: '0, cnt: 2'd0};
        end else if (!stall[MEM_IDX]) begin
            nxt      = '0;
            nxt.hilo = hilo_i;
            nxt.cnt  = cnt_i;
        end else begin
            nxt = model;
        end
        model = nxt;
        sb.push_back(nxt);
        @(negedge clk);
    endtask

    task automatic randomize_ex();
        ex_wd    = ADDR_W'($urandom);
        ex_wreg  = 1'($urandom);
        ex_wdata = $urandom;
        ex_whilo = 1'($urandom);
        ex_hi    = $urandom;
        ex_lo    = $urandom;
        hilo_i   = {$urandom, $urandom};
        cnt_i    = 2'($urandom);
    endtask

    task automatic clear_ex();
        ex_wd = '0; ex_wreg = 1'b0; ex_wdata = '0; ex_whilo = 1'b0;
        ex_hi = '0; ex_lo = '0; hilo_i = '0; cnt_i = 2'd0;
    endtask

    // Monitor: one expected entry per edge, compared just after the edge.
    initial begin
        out_t exp;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                check("scoreboard", 200'(dut_o), 200'(exp));
            end
        end
    end

    // Driver.
    initial begin
        rst = 1'b1; stall = '0; flush = 1'b0;
        clear_ex();
        step();
        rst = 1'b0;
        check("reset_state", 200'(dut_o), 200'(0));

        // Advance
        ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'hDEADBEEF;
        step();
        check("adv_wd", 200'(mem_wd), 200'(5));
        check("adv_wdata", 200'(mem_wdata), 200'(32'hDEADBEEF));
        check("adv_cnt_hilo", 200'({hilo_o, cnt_o}), 200'(0));

        // Bubble, then advance drops the parked state
        stall = 6'b001111; hilo_i = 64'h1_0000_0002; cnt_i = 2'd1;
        step();
        check("bub_req", 200'({mem_wreg, mem_whilo, mem_wdata}), 200'(0));
        check("bub_park", 200'({hilo_o, cnt_o}), 200'({64'h1_0000_0002, 2'd1}));
        stall = '0; clear_ex();
        step();
        check("bub_release", 200'({hilo_o, cnt_o}), 200'(0));

        // Hold for three cycles while ex_* changes
        ex_wd = 5'd7; ex_wdata = 32'h55; ex_wreg = 1'b1;
        step();
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            randomize_ex();
            step();
        end
        check("hold_wd_wdata", 200'({mem_wd, mem_wdata}), 200'({5'd7, 32'h55}));

        // HI/LO pass-through
        stall = '0; clear_ex();
        ex_whilo = 1'b1; ex_hi = 32'h1234; ex_lo = 32'h5678;
        step();
        check("hilo_pass", 200'({mem_whilo, mem_hi, mem_lo}), 200'({1'b1, 32'h1234, 32'h5678}));

        // Reset mid multi-cycle op
        stall = 6'b001111; hilo_i = 64'hCAFE_0000_0000_BEEF; cnt_i = 2'd2;
        step();
        check("park_cnt2", 200'(cnt_o), 200'(2));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("reset_midop", 200'(dut_o), 200'(0));

`ifdef EX_MEM_FLUSH_EN
        stall = '0; randomize_ex(); ex_wreg = 1'b1;
        step();
        flush = 1'b1;
        step();
        check("flush_adv", 200'({mem_wreg, mem_wdata}), 200'(0));
        stall = 6'b001111; randomize_ex();
        flush = 1'b0;
        step();
        stall = 6'b011111; flush = 1'b1;
        step();
        check("flush_hold", 200'(dut_o), 200'(0));
        flush = 1'b0;
`endif

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            randomize_ex();
            stall = STALL_W'($urandom);
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin stall[EX_IDX] = 1'b0; stall[MEM_IDX] = 1'b0; end
                4, 5:       begin stall[EX_IDX] = 1'b1; stall[MEM_IDX] = 1'b0; end
                6, 7, 8:    begin stall[EX_IDX] = 1'b1; stall[MEM_IDX] = 1'b1; end
                default:    begin stall[EX_IDX] = 1'b0; stall[MEM_IDX] = 1'b1; end
            endcase
            rst   = ($urandom_range(0, 39) == 0);
            flush = ($urandom_range(0, 29) == 0);
            step();
        end
        rst = 1'b0; flush = 1'b0;

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 200'(sb.size()), 200'(0));
        $display("illegal stall combinations (EX running, MEM stalled) applied: %0d", illegal_cnt);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
